// File: rtl/tcp_pkt_gen.sv
// TCP segment generator: 5 header words then N incrementing payload words, with the
// checksum accumulated in a CALC phase before the first word is emitted.
module tcp_pkt_gen #(
  parameter logic [15:0] SRC_PORT  = 16'h0400,
  parameter logic [15:0] DES_PORT  = 16'h00aa,
  parameter logic [31:0] SEQ       = 32'h55bc55bc,
  parameter logic [31:0] ACK       = 32'hbc55bc55,
  parameter logic [15:0] URG_PTR   = 16'h0000,
  parameter int unsigned IFG       = 4,
  parameter int unsigned MAX_WORDS = 16378
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] payload_words,
  input  logic [7:0]  flags,
  output logic        busy,
  output logic [31:0] tcp_data_out,
  output logic        tcp_data_valid,
  output logic        done
);

  typedef enum logic [2:0] {StIdle, StCalc, StHeader, StData, StGap} state_e;

  state_e      r_state, w_state_nx;
  logic [15:0] r_n, w_n_nx;
  logic [7:0]  r_flags, w_flags_nx;
  logic [15:0] r_cnt, w_cnt_nx;
  logic [31:0] r_acc, w_acc_nx;
  logic [31:0] r_data, w_data_nx;
  logic        r_valid, w_valid_nx;
  logic        r_done, w_done_nx;

  logic [15:0] w_n_in;
  logic [15:0] w_len;
  logic [31:0] w_hdr_sum;
  logic [31:0] w_pay;
  logic [16:0] w_f1;
  logic [15:0] w_f2;
  logic [15:0] w_csum;

  // Control segments carry no payload; otherwise clamp so LEN fits in 16 bits.
  assign w_n_in = (flags != 8'h00)                ? 16'd0 :
                  (payload_words > 16'(MAX_WORDS)) ? 16'(MAX_WORDS) : payload_words;

  assign w_len     = 16'd20 + {r_n[13:0], 2'b00};
  assign w_hdr_sum = 32'(SRC_PORT) + 32'(DES_PORT) + 32'(SEQ[31:16]) + 32'(SEQ[15:0]) +
                     32'(ACK[31:16]) + 32'(ACK[15:0]) + 32'(r_flags) + 32'(w_len) +
                     32'(URG_PTR);
  assign w_pay     = {16'h0000, r_cnt - 16'd1};
  assign w_f1      = {1'b0, r_acc[15:0]} + {1'b0, r_acc[31:16]};
  assign w_f2      = w_f1[15:0] + {15'h0000, w_f1[16]};
  assign w_csum    = ~w_f2;

  always_comb begin
    w_state_nx = r_state;
    w_n_nx     = r_n;
    w_flags_nx = r_flags;
    w_cnt_nx   = r_cnt;
    w_acc_nx   = r_acc;
    w_data_nx  = 32'h0;
    w_valid_nx = 1'b0;
    w_done_nx  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_n_nx     = w_n_in;
          w_flags_nx = flags;
          w_acc_nx   = 32'h0;
          w_cnt_nx   = 16'd0;
          w_state_nx = StCalc;
        end
      end
      StCalc: begin
        if (r_cnt == 16'd0) begin
          w_acc_nx = w_hdr_sum;
        end else begin
          w_acc_nx = r_acc + {16'h0000, w_pay[31:16]} + {16'h0000, w_pay[15:0]};
        end
        if (r_cnt == r_n) begin
          w_cnt_nx   = 16'd0;
          w_state_nx = StHeader;
        end else begin
          w_cnt_nx = r_cnt + 16'd1;
        end
      end
      StHeader: begin
        w_valid_nx = 1'b1;
        case (r_cnt[2:0])
          3'd0:    w_data_nx = {SRC_PORT, DES_PORT};
          3'd1:    w_data_nx = SEQ;
          3'd2:    w_data_nx = ACK;
          3'd3:    w_data_nx = {8'h00, r_flags, w_len};
          default: w_data_nx = {w_csum, URG_PTR};
        endcase
        if (r_cnt == 16'd4) begin
          w_cnt_nx   = 16'd0;
          w_state_nx = (r_n == 16'd0) ? StGap : StData;
        end else begin
          w_cnt_nx = r_cnt + 16'd1;
        end
      end
      StData: begin
        w_valid_nx = 1'b1;
        w_data_nx  = {16'h0000, r_cnt};
        if (r_cnt == r_n - 16'd1) begin
          w_cnt_nx   = 16'd0;
          w_state_nx = StGap;
        end else begin
          w_cnt_nx = r_cnt + 16'd1;
        end
      end
      StGap: begin
        // Outputs lag state by a cycle, so done lands right after the last word.
        w_done_nx = (r_cnt == 16'd0);
        if (r_cnt == 16'(IFG - 1)) begin
          w_cnt_nx   = 16'd0;
          w_state_nx = StIdle;
        end else begin
          w_cnt_nx = r_cnt + 16'd1;
        end
      end
      default: w_state_nx = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_n     <= 16'd0;
      r_flags <= 8'h00;
      r_cnt   <= 16'd0;
      r_acc   <= 32'h0;
      r_data  <= 32'h0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_n     <= w_n_nx;
      r_flags <= w_flags_nx;
      r_cnt   <= w_cnt_nx;
      r_acc   <= w_acc_nx;
      r_data  <= w_data_nx;
      r_valid <= w_valid_nx;
      r_done  <= w_done_nx;
    end
  end

  assign busy           = (r_state != StIdle);
  assign tcp_data_out   = r_data;
  assign tcp_data_valid = r_valid;
  assign done           = r_done;

endmodule
